// File: rtl/uart_pkg.sv
// Shared types and sizing for the UART receive path.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 13;

  typedef enum logic [2:0] {
    IDLE,
    START_B,
    DATA,
    STOP_B,
    CLEANUP,
    BREAK_WAIT
  } uart_rx_state_t;

endpackage

// File: rtl/uart_receiver_counter.sv
// Free-running up-counter with synchronous clear (priority) and count enable.
module uart_receiver_counter
  import uart_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clock_en,
  input  logic         clear,
  output logic [W-1:0] count
);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      count <= '0;
    else if (clear)    count <= '0;
    else if (clock_en) count <= count + W'(1);
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, valid / framing-error pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter logic [CNT_W-1:0] CLKS_PER_BIT = 13'd1736
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 active_o
);

  localparam logic [CNT_W-1:0] LAST = CLKS_PER_BIT - CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF = LAST >> 1;

  logic                 rx_meta, rx_s;
  uart_rx_state_t       state, next_state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 good;
  logic                 cnt_en, cnt_clear, bit_tick, stop_tick;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  uart_receiver_counter #(.W(CNT_W)) u_clk_cnt (
    .clock    (clk),
    .reset_n  (rst_n),
    .clock_en (cnt_en),
    .clear    (cnt_clear),
    .count    (clk_cnt)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    cnt_en     = 1'b0;
    bit_tick   = 1'b0;
    stop_tick  = 1'b0;
    case (state)
      IDLE:       if (!rx_s) next_state = START_B;
      START_B: begin
        cnt_en = 1'b1;
        if (clk_cnt == HALF) next_state = rx_s ? IDLE : DATA;
      end
      DATA: begin
        cnt_en = 1'b1;
        if (clk_cnt == LAST) begin
          bit_tick = 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) next_state = STOP_B;
        end
      end
      STOP_B: begin
        cnt_en = 1'b1;
        if (clk_cnt == LAST) begin
          stop_tick  = 1'b1;
          next_state = CLEANUP;
        end
      end
      // A bad stop bit with the line still low is a break: park until it releases.
      CLEANUP:    next_state = (good || rx_s) ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (rx_s) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
    cnt_clear = (next_state != state) || bit_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      good        <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      active_o    <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) bit_cnt <= '0;
      else if (bit_tick)       bit_cnt <= bit_cnt + 3'd1;
      if (bit_tick)  shift_reg[bit_cnt] <= rx_s;
      if (stop_tick) good <= rx_s;
      valid_o     <= (state == CLEANUP) && good;
      frame_err_o <= (state == CLEANUP) && !good;
      if ((state == CLEANUP) && good) data_o <= shift_reg;
      active_o    <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench: a fast instance (16 clocks/bit) for protocol cases, a slow one (1736) for real-rate bytes.
module tb_uart_receiver;

  localparam int FAST = 16;
  localparam int SLOW = 1736;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_slow = 1'b1;
  logic [7:0] data, data_slow;
  logic       valid, ferr, active;
  logic       valid_slow, ferr_slow, active_slow;

  int checks = 0;
  int failures = 0;

  int         valid_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  int         active_run = 0, last_run = 0;
  logic [7:0] rx_q[$];
  int         slow_valid = 0, slow_ferr = 0;
  logic [7:0] slow_q[$];

  int v0, f0;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(13'd16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .frame_err_o (ferr),
    .active_o    (active)
  );

  uart_receiver #(.CLKS_PER_BIT(13'd1736)) dut_slow (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_slow),
    .data_o      (data_slow),
    .valid_o     (valid_slow),
    .frame_err_o (ferr_slow),
    .active_o    (active_slow)
  );

  // Pulse monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      rx_q.push_back(data);
    end
    if (ferr) ferr_cnt++;
    if (valid && ferr) both_cnt++;
    if (active) active_run++;
    else if (active_run > 0) begin
      last_run   = active_run;
      active_run = 0;
    end
    if (valid_slow) begin
      slow_valid++;
      slow_q.push_back(data_slow);
    end
    if (ferr_slow) slow_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int cpb, input bit slow);
    if (slow) rx_slow = v;
    else      rx = v;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int cpb, input bit slow);
    send_bit(1'b0, cpb, slow);
    for (int i = 0; i < 8; i++) send_bit(b[i], cpb, slow);
    send_bit(stop_v, cpb, slow);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data",   32'(data),   32'h00);
    check("rst_valid",  32'(valid),  32'h0);
    check("rst_ferr",   32'(ferr),   32'h0);
    check("rst_active", 32'(active), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_active", 32'(active), 32'h0);

    // Single frame 0xA5
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, FAST, 1'b0);
    repeat (32) @(negedge clk);
    check("a5_pulses", 32'(valid_cnt - v0), 32'd1);
    check("a5_qdata",  32'(rx_q[v0]), 32'hA5);
    check("a5_data",   32'(data), 32'hA5);
    check("a5_ferr",   32'(ferr_cnt - f0), 32'd0);
    check("a5_active", 32'(active), 32'h0);

    // Back-to-back 0x00 then 0xFF with no idle gap
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, FAST, 1'b0);
    send_frame(8'hFF, 1'b1, FAST, 1'b0);
    repeat (32) @(negedge clk);
    check("b2b_pulses", 32'(valid_cnt - v0), 32'd2);
    check("b2b_first",  32'(rx_q[v0]), 32'h00);
    check("b2b_second", 32'(rx_q[v0 + 1]), 32'hFF);
    check("b2b_data",   32'(data), 32'hFF);

    // 5-clock glitch on the idle line
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid",  32'(valid_cnt - v0), 32'd0);
    check("glitch_ferr",   32'(ferr_cnt - f0), 32'd0);
    check("glitch_active", 32'(active), 32'h0);
    check("glitch_run_ok", 32'((last_run > 0) && (last_run <= 12)), 32'd1);
    check("glitch_data",   32'(data), 32'hFF);

    // Framing error followed by a 40-bit break
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, FAST, 1'b0);
    rx = 1'b0;
    repeat (40 * FAST) @(negedge clk);
    check("brk_ferr",   32'(ferr_cnt - f0), 32'd1);
    check("brk_valid",  32'(valid_cnt - v0), 32'd0);
    check("brk_data",   32'(data), 32'hFF);
    check("brk_active", 32'(active), 32'h1);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    check("brk_release_ferr",   32'(ferr_cnt - f0), 32'd1);
    check("brk_release_active", 32'(active), 32'h0);
    send_frame(8'h5A, 1'b1, FAST, 1'b0);
    repeat (32) @(negedge clk);
    check("brk_recover_valid", 32'(valid_cnt - v0), 32'd1);
    check("brk_recover_data",  32'(data), 32'h5A);
    check("brk_recover_ferr",  32'(ferr_cnt - f0), 32'd1);

    // Reset during data bit 4 of 0x81, then resend
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0, FAST, 1'b0);
    send_bit(1'b1, FAST, 1'b0);
    send_bit(1'b0, FAST, 1'b0);
    send_bit(1'b0, FAST, 1'b0);
    send_bit(1'b0, FAST, 1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_data",   32'(data), 32'h00);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_valid",  32'(valid), 32'h0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (32) @(negedge clk);
    check("post_rst_active", 32'(active), 32'h0);
    check("post_rst_nopulse", 32'(valid_cnt - v0), 32'd0);
    send_frame(8'h81, 1'b1, FAST, 1'b0);
    repeat (32) @(negedge clk);
    check("resend_valid", 32'(valid_cnt - v0), 32'd1);
    check("resend_data",  32'(data), 32'h81);
    check("resend_ferr",  32'(ferr_cnt - f0), 32'd0);
    check("never_both",   32'(both_cnt), 32'd0);

    // Real-rate bytes at 1736 clocks per bit, back-to-back
    v0 = slow_valid;
    send_frame(8'h00, 1'b1, SLOW, 1'b1);
    send_frame(8'hC3, 1'b1, SLOW, 1'b1);
    send_frame(8'hFF, 1'b1, SLOW, 1'b1);
    repeat (2 * SLOW) @(negedge clk);
    check("slow_pulses", 32'(slow_valid - v0), 32'd3);
    check("slow_b0",     32'(slow_q[v0]), 32'h00);
    check("slow_b1",     32'(slow_q[v0 + 1]), 32'hC3);
    check("slow_b2",     32'(slow_q[v0 + 2]), 32'hFF);
    check("slow_ferr",   32'(slow_ferr), 32'd0);
    check("slow_active", 32'(active_slow), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
